// File: rtl/psw_pkg.sv
// Shared definitions for the password sequence checker and the game control
// logic: FSM state encoding and the default password geometry.
package psw_pkg;

  // Default password geometry used by the game build.
  localparam int PSW_W         = 7;
  localparam int PSW_DIGITS    = 2;
  localparam int PSW_MAX_TRIES = 3;

  // Checker FSM states. DONE_OK and DONE_FAIL are terminal until reset.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ENTRY     = 2'd1,
    DONE_OK   = 2'd2,
    DONE_FAIL = 2'd3
  } psw_state_e;

endpackage

// File: rtl/btn_edge.sv
// Button press detector: registers an already-debounced level and emits a
// single-cycle pulse on its rising edge, however long the button is held.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;

  // Previous-cycle button level, cleared by reset so a held button at
  // reset release still counts as one fresh press.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/psw_sequence_check.sv
// Password sequence checker for the bomb dismantlement game.
// The player enters DIGITS codes of W bits on the switches, each confirmed by
// a button press. Wrong codes burn one of MAX_TRIES attempts; running out
// raises fail, a complete correct sequence raises success. Both are sticky
// until reset. ld mirrors the switches while entry is active.
// Optional build macro PSW_HINT_EN adds a 'hint' output giving the number of
// matching bit positions of the last confirmed code.
module psw_sequence_check
  import psw_pkg::*;
#(
  parameter  int W         = PSW_W,
  parameter  int DIGITS    = PSW_DIGITS,
  parameter  int MAX_TRIES = PSW_MAX_TRIES,
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_input,
  input  logic [W-1:0]          sw,
  input  logic [DIGITS*W-1:0]   psw,
  input  logic                  btn_confirm,
  output logic [W-1:0]          ld,
  output logic                  success,
  output logic                  fail,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [TRY_W-1:0]      tries_left
`ifdef PSW_HINT_EN
  ,
  output logic [$clog2(W+1)-1:0] hint
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [TRY_W-1:0] TRY_FULL  = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);

`ifdef PSW_HINT_EN
  localparam int HINT_W = $clog2(W + 1);

  // Number of bit positions where the two codes agree.
  function automatic logic [HINT_W-1:0] count_equal(input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
    logic [HINT_W-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) n = n + HINT_W'(a[i] ~^ b[i]);
    return n;
  endfunction

  logic [HINT_W-1:0] hint_n;
`endif

  psw_state_e       state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [TRY_W-1:0] tries_n;
  logic             success_n;
  logic             fail_n;
  logic             press;
  logic [W-1:0]     expected;
  logic             match;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_confirm),
    .press (press)
  );

  // Select the digit currently expected; digit 0 sits in the low W bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    expected = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) expected = psw[k*W +: W];
    end
  end

  assign match = (sw == expected);

  // Next-state and next-output logic. An abort (start_input low) takes
  // priority over a press in the same cycle.
  always_comb begin
    state_n   = state;
    idx_n     = digit_idx;
    tries_n   = tries_left;
    success_n = success;
    fail_n    = fail;
`ifdef PSW_HINT_EN
    hint_n    = hint;
`endif
    unique case (state)
      IDLE: begin
        if (start_input) state_n = ENTRY;
      end
      ENTRY: begin
        if (!start_input) begin
          // Abort: restart the sequence, attempts are not refunded.
          state_n = IDLE;
          idx_n   = '0;
        end else if (press) begin
`ifdef PSW_HINT_EN
          hint_n = count_equal(sw, expected);
`endif
          if (match) begin
            if (digit_idx == LAST_IDX) begin
              state_n   = DONE_OK;
              success_n = 1'b1;
            end else begin
              idx_n = digit_idx + IDX_W'(1);
            end
          end else begin
            idx_n   = '0;
            tries_n = tries_left - TRY_ONE;
            if (tries_left == TRY_ONE) begin
              state_n = DONE_FAIL;
              fail_n  = 1'b1;
            end
          end
        end
      end
      DONE_OK, DONE_FAIL: begin
        // Terminal: everything holds until reset.
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and sticky status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      digit_idx  <= '0;
      tries_left <= TRY_FULL;
      success    <= 1'b0;
      fail       <= 1'b0;
`ifdef PSW_HINT_EN
      hint       <= '0;
`endif
    end else begin
      state      <= state_n;
      digit_idx  <= idx_n;
      tries_left <= tries_n;
      success    <= success_n;
      fail       <= fail_n;
`ifdef PSW_HINT_EN
      hint       <= hint_n;
`endif
    end
  end

  // LED mirror: follows the switches only during entry, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ld <= '0;
    else if (state == ENTRY) ld <= sw;
  end

endmodule

// File: tb/tb_psw_sequence_check.sv
// Directed testbench for psw_sequence_check with W=7, DIGITS=2, MAX_TRIES=3
// and password digit0=7'h15, digit1=7'h2A. Inputs change on the falling
// clock edge; outputs are sampled on the falling edge after the active edge.
`timescale 1ns/1ps
module tb_psw_sequence_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_input = 1'b0;
  logic [6:0]  sw = '0;
  logic [13:0] psw = {7'h2A, 7'h15};
  logic        btn_confirm = 1'b0;
  logic [6:0]  ld;
  logic        success;
  logic        fail;
  logic [0:0]  digit_idx;
  logic [1:0]  tries_left;
`ifdef PSW_HINT_EN
  logic [2:0]  obs_hint;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psw_sequence_check #(.W(7), .DIGITS(2), .MAX_TRIES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_input (start_input),
    .sw          (sw),
    .psw         (psw),
    .btn_confirm (btn_confirm),
    .ld          (ld),
    .success     (success),
    .fail        (fail),
    .digit_idx   (digit_idx),
    .tries_left  (tries_left)
`ifdef PSW_HINT_EN
    ,
    .hint        (obs_hint)
`endif
  );

  task automatic apply_reset();
    @(negedge clk);
    start_input = 1'b0;
    btn_confirm = 1'b0;
    sw          = '0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One press of btn_confirm with the given switch value, then one idle cycle
  // so the next press produces a fresh edge. Returns at a falling edge.
  task automatic press(input logic [6:0] value);
    @(negedge clk);
    sw          = value;
    btn_confirm = 1'b1;
    @(negedge clk);
    btn_confirm = 1'b0;
  endtask

  task automatic enter_start();
    @(negedge clk);
    start_input = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (success !== 1'b0) begin errors++; $display("FAIL reset_success got=%b exp=0", success); end
    checks++;
    if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", fail); end
    checks++;
    if (digit_idx !== 1'b0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
    checks++;
    if (tries_left !== 2'd3) begin errors++; $display("FAIL reset_tries got=%0d exp=3", tries_left); end
    checks++;
    if (ld !== 7'h00) begin errors++; $display("FAIL reset_ld got=%h exp=00", ld); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_correct_sequence();
    apply_reset();
    enter_start();
    press(7'h15);
    checks++;
    if (digit_idx !== 1'b1) begin errors++; $display("FAIL seq_idx1 got=%0d exp=1", digit_idx); end
    checks++;
    if (ld !== 7'h15) begin errors++; $display("FAIL seq_ld got=%h exp=15", ld); end
    checks++;
    if (success !== 1'b0) begin errors++; $display("FAIL seq_early_success got=%b exp=0", success); end
    press(7'h2A);
    checks++;
    if (success !== 1'b1) begin errors++; $display("FAIL seq_success got=%b exp=1", success); end
    checks++;
    if (tries_left !== 2'd3) begin errors++; $display("FAIL seq_tries got=%0d exp=3", tries_left); end
    press(7'h00);
    press(7'h7F);
    checks++;
    if ({success, fail, tries_left} !== {1'b1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL seq_terminal got=s%b f%b t%0d exp=s1 f0 t3", success, fail, tries_left);
    end
  endtask

  task automatic test_wrong_then_right();
    apply_reset();
    enter_start();
    press(7'h15);
    press(7'h00);
    checks++;
    if (digit_idx !== 1'b0) begin errors++; $display("FAIL wr_idx got=%0d exp=0", digit_idx); end
    checks++;
    if (tries_left !== 2'd2) begin errors++; $display("FAIL wr_tries got=%0d exp=2", tries_left); end
    press(7'h15);
    press(7'h2A);
    checks++;
    if (success !== 1'b1) begin errors++; $display("FAIL wr_success got=%b exp=1", success); end
  endtask

  task automatic test_exhaust();
    logic [1:0] exp_tries [3];
    exp_tries = '{2'd2, 2'd1, 2'd0};
    apply_reset();
    enter_start();
    for (int i = 0; i < 3; i++) begin
      press(7'h7F);
      checks++;
      if (tries_left !== exp_tries[i]) begin
        errors++;
        $display("FAIL exh_tries%0d got=%0d exp=%0d", i, tries_left, exp_tries[i]);
      end
      checks++;
      if (fail !== (i == 2)) begin
        errors++;
        $display("FAIL exh_fail%0d got=%b exp=%b", i, fail, (i == 2));
      end
    end
    press(7'h15);
    press(7'h2A);
    checks++;
    if ({success, fail} !== 2'b01) begin
      errors++;
      $display("FAIL exh_after got=s%b f%b exp=s0 f1", success, fail);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    enter_start();
    sw          = 7'h00;
    btn_confirm = 1'b1;
    repeat (20) @(negedge clk);
    btn_confirm = 1'b0;
    @(negedge clk);
    checks++;
    if (tries_left !== 2'd2) begin errors++; $display("FAIL hold_tries got=%0d exp=2", tries_left); end
  endtask

  task automatic test_abort();
    apply_reset();
    enter_start();
    press(7'h15);
    start_input = 1'b0;
    @(negedge clk);
    checks++;
    if ({digit_idx, tries_left} !== {1'b0, 2'd3}) begin
      errors++;
      $display("FAIL abort_state got=i%0d t%0d exp=i0 t3", digit_idx, tries_left);
    end
    // A press while idle is ignored.
    press(7'h00);
    checks++;
    if (tries_left !== 2'd3) begin errors++; $display("FAIL idle_press got=%0d exp=3", tries_left); end
    // Abort and press in the same cycle: abort wins.
    enter_start();
    start_input = 1'b0;
    sw          = 7'h00;
    btn_confirm = 1'b1;
    @(negedge clk);
    btn_confirm = 1'b0;
    @(negedge clk);
    checks++;
    if ({digit_idx, tries_left} !== {1'b0, 2'd3}) begin
      errors++;
      $display("FAIL abort_press got=i%0d t%0d exp=i0 t3", digit_idx, tries_left);
    end
    enter_start();
    press(7'h15);
    checks++;
    if (digit_idx !== 1'b1) begin errors++; $display("FAIL reenter_idx got=%0d exp=1", digit_idx); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    enter_start();
    press(7'h7F);
    press(7'h15);
    checks++;
    if ({digit_idx, tries_left} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL pre_rst got=i%0d t%0d exp=i1 t2", digit_idx, tries_left);
    end
    // Assert reset between clock edges and look before the next rising edge.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ld, success, fail, digit_idx, tries_left} !== {7'h00, 1'b0, 1'b0, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL async_rst got=ld%h s%b f%b i%0d t%0d exp=ld00 s0 f0 i0 t3",
               ld, success, fail, digit_idx, tries_left);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef PSW_HINT_EN
  task automatic test_hint();
    apply_reset();
    enter_start();
    press(7'h14);
    checks++;
    if (obs_hint !== 3'd6) begin errors++; $display("FAIL hint_wrong got=%0d exp=6", obs_hint); end
    press(7'h15);
    checks++;
    if (obs_hint !== 3'd7) begin errors++; $display("FAIL hint_right got=%0d exp=7", obs_hint); end
  endtask
`endif

  initial begin
    test_reset();
    test_correct_sequence();
    test_wrong_then_right();
    test_exhaust();
    test_hold();
    test_abort();
    test_async_reset();
`ifdef PSW_HINT_EN
    test_hint();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
